// File: rtl/cu_cta_dispatcher_if.sv
// rtl/cu_cta_dispatcher_if.sv - CTA descriptor handshake bundle toward the warp scheduler
interface cu_cta_dispatcher_if #(
  parameter int CW  = 32,
  parameter int PCW = 32
);
  logic           cta_vld;
  logic           cta_rdy;
  logic [CW-1:0]  cta_id_x;
  logic [CW-1:0]  cta_id_y;
  logic [CW-1:0]  cta_id_z;
  logic [29:0]    cta_ntid;
  logic [PCW-1:0] cta_pc;
  logic           cta_last;

  modport master (
    output cta_vld, cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc, cta_last,
    input  cta_rdy
  );

  modport slave (
    input  cta_vld, cta_id_x, cta_id_y, cta_id_z, cta_ntid, cta_pc, cta_last,
    output cta_rdy
  );
endinterface

// File: rtl/cu_cta_dispatcher.sv
// rtl/cu_cta_dispatcher.sv - walks the 3-D CTA grid of a kernel launch, one descriptor per handshake
module cu_cta_dispatcher #(
  parameter int CW  = 32,
  parameter int PCW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_kernel_start,
  input  logic            i_abort,
  input  logic [11:0]     i_cfg_ntid_x,
  input  logic [11:0]     i_cfg_ntid_y,
  input  logic [5:0]      i_cfg_ntid_z,
  input  logic [CW-1:0]   i_cfg_nctaid_x,
  input  logic [CW-1:0]   i_cfg_nctaid_y,
  input  logic [CW-1:0]   i_cfg_nctaid_z,
  input  logic [PCW-1:0]  i_cfg_init_pc,
  cu_cta_dispatcher_if.master o_cta,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_sta_err_zero,
  output logic            o_sta_aborted,
  output logic [31:0]     o_sta_cta_cnt
);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DISP, S_FIN} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_nx, r_ny, r_nz;
  logic [29:0]     r_ntid;
  logic [PCW-1:0]  r_pc;
  logic [CW-1:0]   r_x, r_y, r_z;
  logic            r_vld, r_last, r_busy, r_done, r_err, r_abt;
  logic [31:0]     r_cnt;

  logic            w_hs, w_zero, w_last_start;
  logic            w_x_end, w_y_end, w_last_nxt;
  logic [CW-1:0]   w_x_nxt, w_y_nxt, w_z_nxt;

  assign w_hs         = r_vld && o_cta.cta_rdy;
  assign w_zero       = (i_cfg_nctaid_x == '0) || (i_cfg_nctaid_y == '0) || (i_cfg_nctaid_z == '0);
  assign w_last_start = (i_cfg_nctaid_x == ONE) && (i_cfg_nctaid_y == ONE) && (i_cfg_nctaid_z == ONE);

  // Grid dims are non-zero in DISP, so n-1 never underflows and n = 2^CW-1 compares cleanly.
  always_comb begin
    w_x_end    = (r_x == r_nx - ONE);
    w_y_end    = (r_y == r_ny - ONE);
    w_x_nxt    = w_x_end ? '0 : r_x + ONE;
    w_y_nxt    = w_x_end ? (w_y_end ? '0 : r_y + ONE) : r_y;
    w_z_nxt    = (w_x_end && w_y_end) ? r_z + ONE : r_z;
    w_last_nxt = (w_x_nxt == r_nx - ONE) && (w_y_nxt == r_ny - ONE) && (w_z_nxt == r_nz - ONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_nx    <= '0;
      r_ny    <= '0;
      r_nz    <= '0;
      r_ntid  <= '0;
      r_pc    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_vld   <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_abt   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_kernel_start) begin
            r_nx   <= i_cfg_nctaid_x;
            r_ny   <= i_cfg_nctaid_y;
            r_nz   <= i_cfg_nctaid_z;
            r_ntid <= {i_cfg_ntid_z, i_cfg_ntid_y, i_cfg_ntid_x};
            r_pc   <= i_cfg_init_pc;
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_err  <= w_zero;
            r_abt  <= 1'b0;
            r_cnt  <= '0;
            if (w_zero) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_DISP;
              r_vld   <= 1'b1;
              r_busy  <= 1'b1;
              r_last  <= w_last_start;
            end
          end
        end
        S_DISP: begin
          if (w_hs) begin
            r_cnt  <= r_cnt + 32'd1;
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_z    <= w_z_nxt;
            r_last <= w_last_nxt;
          end
          // Abort overrides any further advance, but a handshake in the same cycle still counts.
          if (i_abort || (w_hs && r_last)) begin
            r_state <= S_FIN;
            r_vld   <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_abt   <= i_abort;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cta.cta_vld  = r_vld;
  assign o_cta.cta_id_x = r_x;
  assign o_cta.cta_id_y = r_y;
  assign o_cta.cta_id_z = r_z;
  assign o_cta.cta_ntid = r_ntid;
  assign o_cta.cta_pc   = r_pc;
  assign o_cta.cta_last = r_last;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_sta_err_zero = r_err;
  assign o_sta_aborted  = r_abt;
  assign o_sta_cta_cnt  = r_cnt;
endmodule
